// File: rtl/mul_seq_nbit.sv
// ---------------------------------------------------------------------------
// mul_seq_nbit
//   Iterative shift-add multiplier sitting between the tap/coefficient fetch
//   and the accumulator of the FIR datapath. Produces the full 2*WIDTH-bit
//   product of two WIDTH-bit operands, unsigned or two's complement, plus a
//   flag telling whether the product also fits in WIDTH bits.
//
//   Timing (accept edge to first cycle with out_valid=1):
//     normal operation : WIDTH+2 cycles
//     either operand 0 : 1 cycle (p=0, fits=1)
//
// Parameters
//   WIDTH      operand width, >= 2
//   SIGNED_EN  1: is_signed selects the mode, 0: always unsigned
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/mode valid           in_ready   operands accepted
//   a, b       multiplicand / multiplier     is_signed  two's complement mode
//   out_valid  p/fits valid                  out_ready  consumer takes result
//   p          2*WIDTH-bit product           fits       product fits WIDTH bits
// ---------------------------------------------------------------------------
module mul_seq_nbit #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 fits
);

  localparam int unsigned         CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]       LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [2*WIDTH:0]     r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign;
  logic                 r_signed;
  logic [2*WIDTH-1:0]   r_p;
  logic                 r_fits;

  logic                 w_accept;
  logic                 w_mode;
  logic                 w_zero;
  logic                 w_sign;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_upper;
  logic [2*WIDTH:0]     w_acc_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_p_fix;
  logic                 w_fits_fix;

  // -------------------------------------------------------------------------
  // Operand conditioning at accept time
  // -------------------------------------------------------------------------
  always_comb begin
    w_accept = (r_state == S_IDLE) && in_valid;
    w_mode   = SIGNED_EN && is_signed;
    w_zero   = (a == '0) || (b == '0);
    w_sign   = w_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly its magnitude 2^(WIDTH-1).
    w_mag_a  = (w_mode && a[WIDTH-1]) ? -a : a;
    w_mag_b  = (w_mode && b[WIDTH-1]) ? -b : b;
  end

  // -------------------------------------------------------------------------
  // One shift-add iteration and the final sign/fits fix-up
  // -------------------------------------------------------------------------
  always_comb begin
    // Upper half is WIDTH+1 bits wide so the add never loses its carry.
    w_upper    = r_acc[0] ? (r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand})
                          : r_acc[2*WIDTH:WIDTH];
    w_acc_step = {1'b0, w_upper, r_acc[WIDTH-1:1]};

    w_prod     = r_acc[2*WIDTH-1:0];
    w_p_fix    = r_sign ? -w_prod : w_prod;

    if (r_signed) begin
      w_fits_fix = (&w_p_fix[2*WIDTH-1:WIDTH-1]) | ~(|w_p_fix[2*WIDTH-1:WIDTH-1]);
    end else begin
      w_fits_fix = ~(|w_p_fix[2*WIDTH-1:WIDTH]);
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = w_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_signed <= 1'b0;
      r_p      <= '0;
      r_fits   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= w_mag_a;
            r_acc    <= {{(WIDTH+1){1'b0}}, w_mag_b};
            r_cnt    <= '0;
            r_sign   <= w_sign;
            r_signed <= w_mode;
            if (w_zero) begin
              r_p    <= '0;
              r_fits <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_p    <= w_p_fix;
          r_fits <= w_fits_fix;
        end
        default: begin
        end
      endcase
    end
  end

  assign p    = r_p;
  assign fits = r_fits;

endmodule

// File: tb/tb_mul_seq_nbit.sv
module tb_mul_seq_nbit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        is_signed = 1'b0;
  logic [15:0] ta = '0;
  logic [15:0] tbv = '0;
  int          sel = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 0: W=8 signed-capable, 1: W=4, 2: W=16, 3: W=8 with SIGNED_EN=0
  int W_OF  [4] = '{8, 4, 16, 8};
  bit SE_OF [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic        rdy0, rdy1, rdy2, rdy3, ov0, ov1, ov2, ov3, f0, f1, f2, f3;
  logic [15:0] p0;
  logic [7:0]  p1;
  logic [31:0] p2;
  logic [15:0] p3;

  mul_seq_nbit #(.WIDTH(8), .SIGNED_EN(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(rdy0),
    .a(ta[7:0]), .b(tbv[7:0]), .is_signed(is_signed), .out_valid(ov0),
    .out_ready(out_ready), .p(p0), .fits(f0));

  mul_seq_nbit #(.WIDTH(4), .SIGNED_EN(1'b1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(rdy1),
    .a(ta[3:0]), .b(tbv[3:0]), .is_signed(is_signed), .out_valid(ov1),
    .out_ready(out_ready), .p(p1), .fits(f1));

  mul_seq_nbit #(.WIDTH(16), .SIGNED_EN(1'b1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(rdy2),
    .a(ta), .b(tbv), .is_signed(is_signed), .out_valid(ov2),
    .out_ready(out_ready), .p(p2), .fits(f2));

  mul_seq_nbit #(.WIDTH(8), .SIGNED_EN(1'b0)) u_w8u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3), .in_ready(rdy3),
    .a(ta[7:0]), .b(tbv[7:0]), .is_signed(is_signed), .out_valid(ov3),
    .out_ready(out_ready), .p(p3), .fits(f3));

  logic        obs_rdy, obs_ov, obs_f;
  logic [31:0] obs_p;

  always_comb begin
    obs_rdy = rdy0; obs_ov = ov0; obs_f = f0; obs_p = {16'b0, p0};
    case (sel)
      1: begin obs_rdy = rdy1; obs_ov = ov1; obs_f = f1; obs_p = {24'b0, p1}; end
      2: begin obs_rdy = rdy2; obs_ov = ov2; obs_f = f2; obs_p = p2; end
      3: begin obs_rdy = rdy3; obs_ov = ov3; obs_f = f3; obs_p = {16'b0, p3}; end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] p;
    logic        f;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer multiply on sign/zero-extended operands.
  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input bit sg);
    int     w;
    bit     se;
    longint ua, ub, sa, sbb, prod, half;
    exp_t   e;
    w    = W_OF[sel];
    se   = sg && SE_OF[sel];
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & ((longint'(1) << w) - 1);
    ub   = longint'(b) & ((longint'(1) << w) - 1);
    sa   = (se && ua >= half) ? ua - 2 * half : ua;
    sbb  = (se && ub >= half) ? ub - 2 * half : ub;
    prod = sa * sbb;
    e.f  = se ? (prod >= -half && prod < half) : (prod < 2 * half);
    e.p  = 32'(prod & ((longint'(1) << (2 * w)) - 1));
    e.lat = (ua == 0 || ub == 0) ? 1 : w + 2;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit sg);
    int   n;
    bit   busy_ok;
    exp_t e;
    n = 0;
    while (!obs_rdy && n < 50) begin tick(); n++; end
    total++;
    if (obs_rdy !== 1'b1) begin
      bad++; $display("FAIL ready_wait: in_ready=%0b required 1", obs_rdy);
    end
    ta = a; tbv = b; is_signed = sg; in_valid = 1'b1;
    push_exp(a, b, sg);
    tick();
    accept_cyc = cyc;
    in_valid = 1'b0;
    ta = 16'($urandom); tbv = 16'($urandom); is_signed = 1'($urandom);
    n = 1;
    busy_ok = 1'b1;
    while (!obs_ov && n < 100) begin
      if (obs_rdy) busy_ok = 1'b0;
      tick();
      n++;
    end
    if (obs_rdy) busy_ok = 1'b0;
    e = sb.pop_front();
    total++;
    if (n !== e.lat) begin
      bad++; $display("FAIL latency sel=%0d: got %0d required %0d", sel, n, e.lat);
    end
    total++;
    if (!busy_ok) begin
      bad++; $display("FAIL busy_in_ready sel=%0d: in_ready seen 1 while busy", sel);
    end
    total++;
    if (obs_p !== e.p) begin
      bad++; $display("FAIL p sel=%0d a=%0h b=%0h s=%0b: got %0h required %0h", sel, a, b, sg, obs_p, e.p);
    end
    total++;
    if (obs_f !== e.f) begin
      bad++; $display("FAIL fits sel=%0d a=%0h b=%0h s=%0b: got %0b required %0b", sel, a, b, sg, obs_f, e.f);
    end
    if (out_ready) begin
      tick();
      total++;
      if (obs_ov !== 1'b0 || obs_rdy !== 1'b1) begin
        bad++; $display("FAIL return_idle sel=%0d: out_valid=%0b in_ready=%0b required 0/1", sel, obs_ov, obs_rdy);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (ov0 !== 1'b0 || p0 !== 16'h0 || f0 !== 1'b0) begin
      bad++; $display("FAIL in_reset: out_valid=%0b p=%0h fits=%0b required 0/0/0", ov0, p0, f0);
    end
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #0;
      total++;
      if (obs_rdy !== 1'b1 || obs_ov !== 1'b0 || obs_p !== 32'h0 || obs_f !== 1'b0) begin
        bad++; $display("FAIL reset_state sel=%0d: rdy=%0b ov=%0b p=%0h f=%0b required 1/0/0/0",
                        i, obs_rdy, obs_ov, obs_p, obs_f);
      end
    end
    sel = 0;
  endtask

  task automatic test_unsigned();
    sel = 0;
    do_op(16'd255, 16'd255, 1'b0);
    do_op(16'd13, 16'd17, 1'b0);
    do_op(16'd1, 16'd255, 1'b0);
  endtask

  task automatic test_signed();
    sel = 0;
    do_op(16'h00FD, 16'd5, 1'b1);
    do_op(16'h0080, 16'h0080, 1'b1);
    do_op(16'h0080, 16'd1, 1'b1);
    do_op(16'h007F, 16'h0081, 1'b1);
  endtask

  task automatic test_zero();
    sel = 0;
    do_op(16'd0, 16'd200, 1'b0);
    do_op(16'd37, 16'd0, 1'b0);
    do_op(16'd0, 16'h0080, 1'b1);
  endtask

  task automatic test_backpressure();
    sel = 0;
    out_ready = 1'b0;
    do_op(16'd12, 16'd11, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ta = 16'd3; tbv = 16'd3; in_valid = 1'b1;
      tick();
      total++;
      if (obs_ov !== 1'b1 || obs_p !== 32'd132 || obs_f !== 1'b1 || obs_rdy !== 1'b0) begin
        bad++; $display("FAIL hold cycle=%0d: ov=%0b p=%0d f=%0b rdy=%0b required 1/132/1/0",
                        i, obs_ov, obs_p, obs_f, obs_rdy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if (obs_ov !== 1'b0 || obs_rdy !== 1'b1) begin
      bad++; $display("FAIL release: ov=%0b rdy=%0b required 0/1", obs_ov, obs_rdy);
    end
    tick();
    total++;
    if (obs_ov !== 1'b0 || obs_rdy !== 1'b1) begin
      bad++; $display("FAIL single_handshake: ov=%0b rdy=%0b required 0/1", obs_ov, obs_rdy);
    end
  endtask

  task automatic test_reset_mid_calc();
    sel = 0;
    ta = 16'd100; tbv = 16'd100; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs_ov !== 1'b0 || obs_p !== 32'h0 || obs_f !== 1'b0) begin
      bad++; $display("FAIL async_reset: ov=%0b p=%0h f=%0b required 0/0/0", obs_ov, obs_p, obs_f);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++;
    if (obs_rdy !== 1'b1 || obs_ov !== 1'b0) begin
      bad++; $display("FAIL after_reset: rdy=%0b ov=%0b required 1/0", obs_rdy, obs_ov);
    end
    do_op(16'd7, 16'd9, 1'b0);
  endtask

  task automatic test_signed_en0();
    sel = 3;
    do_op(16'h00FF, 16'h0002, 1'b1);
    do_op(16'h00FD, 16'd5, 1'b1);
    sel = 0;
  endtask

  task automatic test_widths();
    sel = 1;
    do_op(16'd15, 16'd15, 1'b0);
    do_op(16'h000D, 16'd5, 1'b1);
    do_op(16'h0008, 16'h0008, 1'b1);
    do_op(16'h0008, 16'd1, 1'b1);
    sel = 2;
    do_op(16'hFFFF, 16'hFFFF, 1'b0);
    do_op(16'hFFFD, 16'd5, 1'b1);
    do_op(16'h8000, 16'h8000, 1'b1);
    do_op(16'h8000, 16'd1, 1'b1);
    sel = 0;
  endtask

  task automatic test_back_to_back();
    int prev;
    sel = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_op(16'($urandom_range(1, 255)), 16'($urandom_range(1, 255)), 1'($urandom));
      if (i > 0) begin
        total++;
        if (accept_cyc - prev !== 11) begin
          bad++; $display("FAIL throughput: got %0d cycles required 11", accept_cyc - prev);
        end
      end
      prev = accept_cyc;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_signed_en0();
    test_widths();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
